mmio_hub: RTL
=============

// Module: mmio_hub
// PURPOSE
//  Parametrised memory-mapped I/O hub between the CPU data port and NSLV peripheral slaves
//  (timer/LED/digit block, UART, future units). Provides address decode, a request/ack
//  handshake to each slave and a registered read-data return. Also aggregates per-slave
//  interrupts into one masked, prioritised irq with a source id for the controller.
// PARAMETERS
//  NSLV       4             number of slave channels (1..16)
//  AW         32            address width
//  DW         32            data width
//  BASE       32'h4000_0000 base address of slave window 0
//  SPAN_LOG2  8             log2 bytes per slave window; window i = BASE + (i<<SPAN_LOG2)
//  TMO_CYC    255           slave timeout in cycles (used only with MMIO_HUB_TIMEOUT_EN)
// PORTS
//  clk        in   1          system clock
//  reset      in   1          asynchronous, active-low reset
//  cpu_rd     in   1          CPU read request; held until cpu_ack
//  cpu_wr     in   1          CPU write request; held until cpu_ack
//  cpu_addr   in   AW         byte address
//  cpu_wdata  in   DW         write data
//  cpu_rdata  out  DW         read data; valid while cpu_ack=1
//  cpu_ack    out  1          one-cycle completion pulse
//  cpu_err    out  1          with cpu_ack: unmapped, illegal or timed-out access
//  slv_rd     out  NSLV       per-slave read strobe, held until that slave's ack
//  slv_wr     out  NSLV       per-slave write strobe, held until that slave's ack
//  slv_addr   out  SPAN_LOG2  offset within the selected window
//  slv_wdata  out  DW         latched write data
//  slv_rdata  in   NSLV*DW    packed slave read data; slave i at [i*DW +: DW]
//  slv_ack    in   NSLV       slave completion, one cycle
//  slv_irq    in   NSLV       slave interrupt, level; rising edge is the event
//  irq        out  1          |(pend & mask), registered
//  irq_id     out  4          lowest index of pend & mask; 0 if none
// BEHAVIOUR
//  - Reset: FSM=IDLE; cpu_ack, cpu_err, irq, slv_rd, slv_wr = 0; cpu_rdata, slv_addr,
//    slv_wdata, irq_id = 0; pend = 0; mask = all 1s; err_addr = 0; irq_q edge regs = 0.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. Requests are sampled only in IDLE.
//  - IDLE, rd^wr, slave window: latch index, offset and wdata; go to ACCESS.
//    Strobes rise on the next cycle.
//  - ACCESS: hold the strobe until slv_ack[sel]. On ack, capture slv_rdata[sel]
//    (zero for writes), drop the strobe and go to RESP. Acks from unselected slaves are ignored.
//  - Hub registers at window NSLV, offsets 0x0 PEND(RO), 0x4 MASK(RW), 0x8 ACK(W1C pend),
//    0xC ERRADDR(RO): IDLE -> RESP directly; hub-register access latency is 1 cycle.
//  - Unmapped address (also unused hub offsets), or rd&wr both high: IDLE -> RESP with
//    cpu_err=1 and rdata=0; err_addr <= cpu_addr.
//  - RESP: cpu_ack=1 for exactly one cycle, then IDLE. The CPU must drop its request in the
//    ack cycle, so the next sample in IDLE sees the new request.
//  - IRQ: pend[i] is set on the rising edge of slv_irq[i] and cleared by an ACK write bit.
//    If set and clear land in the same cycle, set wins. irq and irq_id are registered,
//    1 cycle after pend/mask change.
//  - Reset mid-access: strobes drop asynchronously; no ack is issued.
// CONFIGURATION
//  MMIO_HUB_TIMEOUT_EN defined: ACCESS counts cycles. When the count reaches TMO_CYC with
//    no ack, the hub drops the strobe, sets err_addr and goes to RESP with cpu_err=1 and
//    rdata=0. A slave ack arriving later is ignored.
//  MMIO_HUB_TIMEOUT_EN undefined: ACCESS waits indefinitely, no counter is built, and
//    cpu_err covers only decode errors.
// STRUCTURE
//  Package mmio_hub_pkg holds:
//    - the state enum (IDLE/ACCESS/RESP)
//    - hub register offsets (PEND/MASK/ACK/ERRADDR)
//    - the HUB_WIN index helper
//  Sub-module mmio_irq_ctrl holds edge detect, pend, mask, W1C and the priority encoder.
//  The top holds decode, FSM and data muxing.
// TESTING
//  1. Reset then read PEND/MASK -> 1-cycle ack; PEND=0, MASK=0xF, cpu_err=0.
//  2. Write 0x1234 to BASE+0x104, slave1 acks 3 cycles later ->
//     slv_wr[1] high 3 cycles, slv_addr=0x04, single cpu_ack, cpu_err=0.
//  3. Read slave2; slave2 returns 0xCAFE with ack and slave0 asserts a spurious ack ->
//     rdata=0xCAFE; slave0 ack ignored.
//  4. Access BASE+0x600 (unmapped) -> cpu_ack with cpu_err=1, rdata=0,
//     ERRADDR reads 0x4000_0600.
//  5. slv_irq[3] and [1] rise, MASK=0xF -> irq=1, irq_id=1. ACK write 0x2 -> irq_id=3.
//     ACK 0x8 in the same cycle as a new edge on [3] -> pend[3] stays 1.
//  6. With TIMEOUT_EN, slave never acks -> cpu_err ack after TMO_CYC cycles.
//     Without TIMEOUT_EN, no ack for 1000 cycles. Reset asserted mid-ACCESS -> strobes 0 at once.

Source files
------------

// File: rtl/mmio_hub_pkg.sv
// Shared types and constants for the MMIO hub: FSM states, hub register offsets
// and the index of the hub's own register window.
package mmio_hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } hub_state_e;

    localparam logic [7:0] OFF_PEND    = 8'h00;
    localparam logic [7:0] OFF_MASK    = 8'h04;
    localparam logic [7:0] OFF_ACK     = 8'h08;
    localparam logic [7:0] OFF_ERRADDR = 8'h0C;

    // The hub's own registers sit in the window right after the last slave.
    function automatic logic [4:0] hub_win(input int unsigned nslv);
        return 5'(nslv);
    endfunction

endpackage

// File: rtl/mmio_irq_ctrl.sv
// Interrupt aggregation: rising-edge capture into pend, W1C clear, mask and a
// lowest-index-first priority encoder with registered irq/irq_id.
module mmio_irq_ctrl
    import mmio_hub_pkg::*;
#(
    parameter int NSLV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSLV-1:0] slv_irq,
    input  logic            mask_we,
    input  logic [NSLV-1:0] mask_wdata,
    input  logic            ack_we,
    input  logic [NSLV-1:0] ack_wdata,
    output logic [NSLV-1:0] pend,
    output logic [NSLV-1:0] mask,
    output logic            irq,
    output logic [3:0]      irq_id
);

    logic [NSLV-1:0] irq_q_r;
    logic [NSLV-1:0] pend_r;
    logic [NSLV-1:0] mask_r;
    logic [NSLV-1:0] rise_s;
    logic [NSLV-1:0] clr_s;
    logic [NSLV-1:0] act_s;
    logic [3:0]      id_s;

    assign pend = pend_r;
    assign mask = mask_r;

    // Edge detect, clear vector and active set.
    always_comb begin
        rise_s = slv_irq & ~irq_q_r;
        if (ack_we) begin
            clr_s = ack_wdata;
        end else begin
            clr_s = {NSLV{1'b0}};
        end
        act_s = pend_r & mask_r;
    end

    // Priority encoder: scanning downward leaves the lowest active index.
    always_comb begin
        id_s = 4'd0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            id_s = act_s[i] ? 4'(i) : id_s;
        end
    end

    // Pending/mask state and registered interrupt outputs; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q_r <= {NSLV{1'b0}};
            pend_r  <= {NSLV{1'b0}};
            mask_r  <= {NSLV{1'b1}};
            irq     <= 1'b0;
            irq_id  <= 4'd0;
        end else begin
            irq_q_r <= slv_irq;
            pend_r  <= (pend_r & ~clr_s) | rise_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
            irq    <= |act_s;
            irq_id <= id_s;
        end
    end

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: address decode, request/ack handshake to NSLV slaves, hub registers
// and registered CPU response. Optional slave timeout via MMIO_HUB_TIMEOUT_EN.
module mmio_hub
    import mmio_hub_pkg::*;
#(
    parameter int              NSLV      = 4,
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter logic [AW-1:0]   BASE      = 32'h4000_0000,
    parameter int              SPAN_LOG2 = 8,
    parameter int              TMO_CYC   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    output logic [NSLV-1:0]      slv_rd,
    output logic [NSLV-1:0]      slv_wr,
    output logic [SPAN_LOG2-1:0] slv_addr,
    output logic [DW-1:0]        slv_wdata,
    input  logic [NSLV*DW-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ack,
    input  logic [NSLV-1:0]      slv_irq,
    output logic                 irq,
    output logic [3:0]           irq_id
);

    hub_state_e           state_r;
    hub_state_e           state_nxt_s;
    logic [AW-1:0]        rel_s;
    logic [AW-1:0]        win_s;
    logic [SPAN_LOG2-1:0] off_s;
    logic [3:0]           idx_s;
    logic [NSLV-1:0]      onehot_s;
    logic                 in_range_s;
    logic                 slave_hit_s;
    logic                 hub_hit_s;
    logic [3:0]           sel_r;
    logic                 is_wr_r;
    logic [DW-1:0]        sel_rdata_s;
    logic                 sel_ack_s;
    logic [DW-1:0]        hub_rdata_s;
    logic                 start_s;
    logic                 hub_go_s;
    logic                 err_go_s;
    logic                 done_s;
    logic                 tmo_s;
    logic                 mask_we_s;
    logic                 ack_we_s;
    logic [NSLV-1:0]      pend_s;
    logic [NSLV-1:0]      mask_s;
    logic [AW-1:0]        err_addr_r;

    // Address decode relative to BASE.
    always_comb begin
        rel_s       = cpu_addr - BASE;
        win_s       = rel_s >> SPAN_LOG2;
        off_s       = rel_s[SPAN_LOG2-1:0];
        idx_s       = win_s[3:0];
        in_range_s  = (cpu_addr >= BASE);
        slave_hit_s = in_range_s && (win_s < AW'(NSLV));
        hub_hit_s   = in_range_s && (win_s == AW'(hub_win(NSLV))) &&
                      ((off_s == SPAN_LOG2'(OFF_PEND)) || (off_s == SPAN_LOG2'(OFF_MASK)) ||
                       (off_s == SPAN_LOG2'(OFF_ACK))  || (off_s == SPAN_LOG2'(OFF_ERRADDR)));
        for (int i = 0; i < NSLV; i++) begin
            onehot_s[i] = (idx_s == 4'(i));
        end
    end

    // Selected slave's data/ack; other slaves' acks never reach the FSM.
    always_comb begin
        sel_rdata_s = {DW{1'b0}};
        sel_ack_s   = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata_s = sel_rdata_s | ((sel_r == 4'(i)) ? slv_rdata[i*DW +: DW] : {DW{1'b0}});
            sel_ack_s   = sel_ack_s | ((sel_r == 4'(i)) & slv_ack[i]);
        end
    end

    // Hub register read mux.
    always_comb begin
        case (off_s)
            SPAN_LOG2'(OFF_PEND):    hub_rdata_s = DW'(pend_s);
            SPAN_LOG2'(OFF_MASK):    hub_rdata_s = DW'(mask_s);
            SPAN_LOG2'(OFF_ERRADDR): hub_rdata_s = DW'(err_addr_r);
            default:                 hub_rdata_s = {DW{1'b0}};
        endcase
    end

`ifdef MMIO_HUB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_r;

    // Cycles spent in ACCESS for the current transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_ACCESS) && !done_s && !tmo_s) begin
            tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end
    end
`endif

    // Next-state logic and one-cycle action strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        hub_go_s    = 1'b0;
        err_go_s    = 1'b0;
        done_s      = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_rd && cpu_wr) begin
                    err_go_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (!(cpu_rd || cpu_wr)) begin
                    state_nxt_s = ST_IDLE;
                end else if (slave_hit_s) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_ACCESS;
                end else if (hub_hit_s) begin
                    hub_go_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    err_go_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (sel_ack_s) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_RESP;
`ifdef MMIO_HUB_TIMEOUT_EN
                end else if (tmo_cnt_r == CNT_W'(TMO_CYC - 1)) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_RESP;
`endif
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign mask_we_s = hub_go_s & cpu_wr & (off_s == SPAN_LOG2'(OFF_MASK));
    assign ack_we_s  = hub_go_s & cpu_wr & (off_s == SPAN_LOG2'(OFF_ACK));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Response, strobe and latched-request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= {DW{1'b0}};
            slv_rd     <= {NSLV{1'b0}};
            slv_wr     <= {NSLV{1'b0}};
            slv_addr   <= {SPAN_LOG2{1'b0}};
            slv_wdata  <= {DW{1'b0}};
            sel_r      <= 4'd0;
            is_wr_r    <= 1'b0;
            err_addr_r <= {AW{1'b0}};
        end else begin
            cpu_ack <= hub_go_s | err_go_s | done_s | tmo_s;
            cpu_err <= err_go_s | tmo_s;
            if (hub_go_s && cpu_rd) begin
                cpu_rdata <= hub_rdata_s;
            end else if (done_s && !is_wr_r) begin
                cpu_rdata <= sel_rdata_s;
            end else begin
                cpu_rdata <= {DW{1'b0}};
            end
            if (start_s) begin
                sel_r     <= idx_s;
                is_wr_r   <= cpu_wr;
                slv_addr  <= off_s;
                slv_wdata <= cpu_wdata;
                slv_rd    <= cpu_rd ? onehot_s : {NSLV{1'b0}};
                slv_wr    <= cpu_wr ? onehot_s : {NSLV{1'b0}};
            end else if (done_s || tmo_s) begin
                slv_rd <= {NSLV{1'b0}};
                slv_wr <= {NSLV{1'b0}};
            end
            // A timed-out access reports the address rebuilt from the latched window.
            if (err_go_s) begin
                err_addr_r <= cpu_addr;
            end else if (tmo_s) begin
                err_addr_r <= BASE + (AW'(sel_r) << SPAN_LOG2) + AW'(slv_addr);
            end
        end
    end

    mmio_irq_ctrl #(
        .NSLV (NSLV)
    ) u_irq (
        .clk        (clk),
        .reset      (reset),
        .slv_irq    (slv_irq),
        .mask_we    (mask_we_s),
        .mask_wdata (cpu_wdata[NSLV-1:0]),
        .ack_we     (ack_we_s),
        .ack_wdata  (cpu_wdata[NSLV-1:0]),
        .pend       (pend_s),
        .mask       (mask_s),
        .irq        (irq),
        .irq_id     (irq_id)
    );

endmodule
